// File: rtl/uart.sv
// uart: full-duplex 8N1 serial port with a req/ack byte interface.
//
// The transmitter serialises a byte accepted from txreq/txdata onto tx.
// The receiver synchronises rx, deserialises one frame and presents the byte
// on rxdata/rxreq until the consumer answers with rxack.
//
// Ports
//   clk     system clock, rising edge
//   rstn    asynchronous active-low reset
//   tx      serial transmit line, idles high
//   rx      serial receive line, asynchronous to clk, idles high
//   txreq   transmit request; txdata is sampled when the transmitter is idle
//   txack   one-cycle pulse in the last cycle of the stop bit
//   txdata  byte to transmit
//   rxreq   received byte available; held until rxack
//   rxack   consumer has taken rxdata
//   rxdata  last received byte
//
// Both FSMs share the same state encoding:
//   state   | meaning
//   S_IDLE  | line idle, waiting for txreq (TX) or a low rx (RX)
//   S_START | start bit in progress
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit in progress
module uart #(
  parameter int BAUDDIV = 868
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       tx,
  input  logic       rx,
  input  logic       txreq,
  output logic       txack,
  input  logic [7:0] txdata,
  output logic       rxreq,
  input  logic       rxack,
  output logic [7:0] rxdata
);

  localparam int CW = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUDDIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUDDIV / 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------------------------------------------------------- TX
  state_e          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (txreq) begin
          tx_state_d = S_START;
          tx_cnt_d   = BIT_LOAD;
          tx_shift_d = txdata;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = BIT_LOAD;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LOAD;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    // tx is registered from the next state so the line is glitch-free and
    // falls in the cycle right after the accept.
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign txack = (tx_state_q == S_STOP) && (tx_cnt_q == '0);

  // ---------------------------------------------------------------- RX
  logic            rx_s1_q, rx_s2_q;
  state_e          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rxreq_q, rxreq_d;
  logic [7:0]      rxdata_q, rxdata_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rxreq_q    <= 1'b0;
      rxdata_q   <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rxreq_q    <= rxreq_d;
      rxdata_q   <= rxdata_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rxreq_d    = rxreq_q;
    rxdata_d   = rxdata_q;
    if (rxack && rxreq_q) rxreq_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_state_d = S_DATA;
            rx_cnt_d   = BIT_LOAD;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LOAD;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = S_IDLE;
          // A byte is delivered only with a valid stop bit and a free
          // holding register; an ack in this same cycle frees it.
          if (rx_s2_q && (!rxreq_q || rxack)) begin
            rxdata_d = rx_shift_q;
            rxreq_d  = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign rxreq  = rxreq_q;
  assign rxdata = rxdata_q;

endmodule

// File: tb/tb_uart.sv
module tb_uart;
  localparam int BD = 4;

  logic       clk;
  logic       rstn;
  logic       tx;
  logic       rx;
  logic       txreq;
  logic       txack;
  logic [7:0] txdata;
  logic       rxreq;
  logic       rxack;
  logic [7:0] rxdata;
  logic       rx_drv;
  logic       loop_en;

  int total = 0;
  int bad   = 0;

  assign rx = loop_en ? tx : rx_drv;

  uart #(.BAUDDIV(BD)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .tx     (tx),
    .rx     (rx),
    .txreq  (txreq),
    .txack  (txack),
    .txdata (txdata),
    .rxreq  (rxreq),
    .rxack  (rxack),
    .rxdata (rxdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one serial frame on rx_drv, starting at a falling clock edge.
  task automatic send_rx(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (BD) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_txack(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (txack === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    logic [9:0] frame;
    int         cyc;
    bit         seen;
    bit         saw_ack;

    rstn    = 1'b0;
    txreq   = 1'b0;
    txdata  = 8'h00;
    rxack   = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_txack", txack, 0);
    check("rst_rxreq", rxreq, 0);
    check("rst_rxdata", rxdata, 8'h00);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single TX of A5, txdata/txreq changes after accept must be ignored
    txdata = 8'hA5;
    txreq  = 1'b1;
    @(negedge clk);
    txreq  = 1'b0;
    txdata = 8'hFF;
    frame  = 10'b1_1010_0101_0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("tx_a5_c%0d", k), tx, frame[k / BD]);
      check($sformatf("txack_a5_c%0d", k), txack, (k == 39) ? 1 : 0);
      @(negedge clk);
    end
    check("tx_a5_idle", tx, 1);
    check("txack_a5_after", txack, 0);
    repeat (3) @(negedge clk);

    // back-to-back TX of 00
    txdata = 8'h00;
    txreq  = 1'b1;
    @(negedge clk);
    txreq = 1'b0;
    wait_txack(60, cyc, seen);
    check("b2b_ack1_seen", seen, 1);
    check("b2b_ack1_lat", cyc, 39);
    txreq = 1'b1;
    @(negedge clk);
    check("b2b_gap_high", tx, 1);
    @(negedge clk);
    txreq = 1'b0;
    check("b2b_start2", tx, 0);
    wait_txack(60, cyc, seen);
    check("b2b_ack2_seen", seen, 1);
    repeat (3) @(negedge clk);

    // loopback 3C
    loop_en = 1'b1;
    txdata  = 8'h3C;
    txreq   = 1'b1;
    @(negedge clk);
    txreq = 1'b0;
    cyc = 0;
    while (rxreq !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check("lb_rxreq", rxreq, 1);
    check("lb_rxdata", rxdata, 8'h3C);
    check("lb_latency_ok", (cyc >= 36 && cyc <= 48) ? 1 : 0, 1);
    repeat (5) @(negedge clk);
    loop_en = 1'b0;
    check("lb_hold_rxreq", rxreq, 1);
    check("lb_hold_rxdata", rxdata, 8'h3C);
    rxack = 1'b1;
    @(negedge clk);
    rxack = 1'b0;
    check("lb_ack_clear", rxreq, 0);
    repeat (4) @(negedge clk);

    // one-cycle glitch
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_rxreq", rxreq, 0);

    // framing error on 55
    send_rx(8'h55, 1'b0);
    repeat (8) @(negedge clk);
    check("frm_rxreq", rxreq, 0);
    check("frm_rxdata", rxdata, 8'h3C);

    // overrun
    send_rx(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_11_req", rxreq, 1);
    check("ovr_11_data", rxdata, 8'h11);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_22_req", rxreq, 1);
    check("ovr_22_data", rxdata, 8'h11);
    rxack = 1'b1;
    @(negedge clk);
    rxack = 1'b0;
    check("ovr_ack_clear", rxreq, 0);
    send_rx(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_33_req", rxreq, 1);
    check("ovr_33_data", rxdata, 8'h33);
    rxack = 1'b1;
    @(negedge clk);
    rxack = 1'b0;
    check("ovr_33_clear", rxreq, 0);
    repeat (2) @(negedge clk);

    // reset in the middle of a TX frame
    txdata = 8'h00;
    txreq  = 1'b1;
    @(negedge clk);
    txreq = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_tx_low", tx, 0);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_txack", txack, 0);
    check("mid_rst_rxdata", rxdata, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    saw_ack = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txack === 1'b1 || tx !== 1'b1) saw_ack = 1'b1;
    end
    check("mid_no_ack_line_idle", saw_ack, 0);
    check("mid_no_rxreq", rxreq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
